// File: rtl/kinase_activity_ctrl.sv
// rtl/kinase_activity_ctrl.sv - LOAD/MIX/WASH/ELUTE valve and pump sequencer for a kinase-activity assay chip
module kinase_activity_ctrl #(
    parameter int PHASE_CYCLES = 4,
    parameter int LOAD_CYCLES  = 64,
    parameter int MIX_ROUNDS   = 16,
    parameter int WASH_CYCLES  = 32,
    parameter int ELUTE_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state,
    output logic [12:0] c,
    output logic [3:0]  s,
    output logic [4:0]  p
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MIX   = 3'd2,
        S_WASH  = 3'd3,
        S_ELUTE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int MIX_CYCLES = MIX_ROUNDS * 3 * PHASE_CYCLES;
    localparam int MAX_LM     = (LOAD_CYCLES > MIX_CYCLES) ? LOAD_CYCLES : MIX_CYCLES;
    localparam int MAX_WE     = (WASH_CYCLES > ELUTE_CYCLES) ? WASH_CYCLES : ELUTE_CYCLES;
    localparam int MAX_DWELL  = (MAX_LM > MAX_WE) ? MAX_LM : MAX_WE;
    localparam int DW         = $clog2(MAX_DWELL + 1);
    localparam int PW         = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    // Dwell counter counts 0..N-1 within a state; the last count triggers the exit.
    localparam logic [DW-1:0] LOAD_LAST  = DW'(LOAD_CYCLES - 1);
    localparam logic [DW-1:0] MIX_LAST   = DW'(MIX_CYCLES - 1);
    localparam logic [DW-1:0] WASH_LAST  = DW'(WASH_CYCLES - 1);
    localparam logic [DW-1:0] ELUTE_LAST = DW'(ELUTE_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(PHASE_CYCLES - 1);

    localparam logic [12:0] C_SAFE = 13'h1FFF;
    localparam logic [3:0]  S_SAFE = 4'hF;
    localparam logic [4:0]  P_SAFE = 5'h1F;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [1:0]    ph_q, ph_d;
    logic [12:0]   c_q, c_d;
    logic [3:0]    s_q, s_d;
    logic [4:0]    p_q, p_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    rot3;
    logic [1:0]    alt2;

    // Next state, counters, and the output pattern for the state/phase being entered.
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q + DW'(1);
        phase_cnt_d = phase_cnt_q + PW'(1);
        ph_d        = ph_q;
        c_d         = C_SAFE;
        s_d         = S_SAFE;
        p_d         = P_SAFE;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        rot3        = 3'b110;
        alt2        = 2'b10;

        if (phase_cnt_q == PH_LAST) begin
            phase_cnt_d = '0;
            ph_d        = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
        end

        case (state_q)
            S_IDLE:  if (start)                   state_d = S_LOAD;
            S_LOAD:  if (dwell_q == LOAD_LAST)    state_d = S_MIX;
            S_MIX:   if (dwell_q == MIX_LAST)     state_d = S_WASH;
            S_WASH:  if (dwell_q == WASH_LAST)    state_d = S_ELUTE;
            S_ELUTE: if (dwell_q == ELUTE_LAST)   state_d = S_DONE;
            S_DONE:                               state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end

        // Every state entry restarts dwell and pump phasing; idle/done keep them cleared.
        if (state_d != state_q || state_d == S_IDLE || state_d == S_DONE) begin
            dwell_d     = '0;
            phase_cnt_d = '0;
            ph_d        = 2'd0;
        end

        case (ph_d)
            2'd0:    rot3 = 3'b110;
            2'd1:    rot3 = 3'b101;
            default: rot3 = 3'b011;
        endcase
        alt2 = ph_d[0] ? 2'b01 : 2'b10;

        case (state_d)
            S_LOAD: begin
                c_d[2:0] = 3'b000;
                p_d[2:0] = rot3;
                busy_d   = 1'b1;
            end
            S_MIX: begin
                c_d[6:3] = 4'b0000;
                p_d[2:0] = rot3;
                busy_d   = 1'b1;
            end
            S_WASH: begin
                c_d[8:7] = 2'b00;
                s_d      = 4'hF;
                p_d[4:3] = alt2;
                busy_d   = 1'b1;
            end
            S_ELUTE: begin
                c_d[12:9] = 4'b0000;
                s_d       = 4'h0;
                busy_d    = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered control lines; reset forces the safe pattern at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dwell_q     <= '0;
            phase_cnt_q <= '0;
            ph_q        <= 2'd0;
            c_q         <= C_SAFE;
            s_q         <= S_SAFE;
            p_q         <= P_SAFE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            phase_cnt_q <= phase_cnt_d;
            ph_q        <= ph_d;
            c_q         <= c_d;
            s_q         <= s_d;
            p_q         <= p_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign c     = c_q;
    assign s     = s_q;
    assign p     = p_q;

endmodule

// File: tb/tb_kinase_activity_ctrl.sv
// tb/tb_kinase_activity_ctrl.sv - self-checking bench for kinase_activity_ctrl
module tb_kinase_activity_ctrl;

    logic clk = 1'b0;
    logic rst, start, abort;

    logic        a_busy, a_done, b_busy, b_done;
    logic [2:0]  a_state, b_state;
    logic [12:0] a_c, b_c;
    logic [3:0]  a_s, b_s;
    logic [4:0]  a_p, b_p;

    localparam int TOT_A = 64 + 16*3*4 + 32 + 32;
    localparam int TOT_B = 1 + 1*3*1 + 1 + 1;
    localparam logic [26:0] SAFE = {3'd0, 1'b0, 1'b0, 13'h1FFF, 4'hF, 5'h1F};

    kinase_activity_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(a_busy), .done(a_done), .state(a_state), .c(a_c), .s(a_s), .p(a_p)
    );

    kinase_activity_ctrl #(
        .PHASE_CYCLES(1), .LOAD_CYCLES(1), .MIX_ROUNDS(1), .WASH_CYCLES(1), .ELUTE_CYCLES(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(b_busy), .done(b_done), .state(b_state), .c(b_c), .s(b_s), .p(b_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic        bz;
        logic        dn;
        logic [12:0] c;
        logic [3:0]  s;
        logic [4:0]  p;
    } vec_t;

    vec_t tbl[16];
    int   vectors = 0;
    int   miscompares = 0;
    int   pos_a, pos_b;
    int   cyc;

    // Protocol position: -1 idle, else cycles since protocol start (total = DONE cycle).
    function automatic logic [26:0] model_out(int pos, int pc, int l, int mr, int w, int e);
        int m, t, ph;
        logic [2:0]  st, rot3;
        logic [1:0]  alt2;
        logic        bz, dn;
        logic [12:0] cc;
        logic [3:0]  ss;
        logic [4:0]  pp;
        m = mr * 3 * pc;
        st = 3'd0; bz = 1'b0; dn = 1'b0; cc = 13'h1FFF; ss = 4'hF; pp = 5'h1F;
        t = 0;
        if (pos >= 0 && pos < l)                      begin st = 3'd1; t = pos; end
        else if (pos >= l && pos < l+m)               begin st = 3'd2; t = pos - l; end
        else if (pos >= l+m && pos < l+m+w)           begin st = 3'd3; t = pos - l - m; end
        else if (pos >= l+m+w && pos < l+m+w+e)       begin st = 3'd4; t = pos - l - m - w; end
        else if (pos == l+m+w+e)                      begin st = 3'd5; end
        ph = (t / pc) % 3;
        rot3 = (ph == 0) ? 3'b110 : (ph == 1) ? 3'b101 : 3'b011;
        alt2 = (ph % 2 == 0) ? 2'b10 : 2'b01;
        case (st)
            3'd1: begin bz = 1'b1; cc[2:0] = 3'b000;  pp[2:0] = rot3; end
            3'd2: begin bz = 1'b1; cc[6:3] = 4'b0000; pp[2:0] = rot3; end
            3'd3: begin bz = 1'b1; cc[8:7] = 2'b00;   pp[4:3] = alt2; end
            3'd4: begin bz = 1'b1; cc[12:9] = 4'b0000; ss = 4'h0; end
            3'd5: dn = 1'b1;
            default: ;
        endcase
        return {st, bz, dn, cc, ss, pp};
    endfunction

    function automatic int model_next(int pos, logic r, logic st, logic ab, int total);
        if (r || ab)      return -1;
        if (pos < 0)      return st ? 0 : -1;
        if (pos >= total) return -1;
        return pos + 1;
    endfunction

    task automatic check(string name, logic [26:0] act, logic [26:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_inv(string name, logic [26:0] act);
        logic bad;
        bad = ((act[11:9] != 3'b111) && (act[21:18] != 4'hF)) || (act[23] && act[22]);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s invariant: outputs %h", name, act);
        end
    endtask

    function automatic logic [26:0] act_a();
        return {a_state, a_busy, a_done, a_c, a_s, a_p};
    endfunction

    function automatic logic [26:0] act_b();
        return {b_state, b_busy, b_done, b_c, b_s, b_p};
    endfunction

    task automatic step();
        @(posedge clk);
        pos_a = model_next(pos_a, rst, start, abort, TOT_A);
        pos_b = model_next(pos_b, rst, start, abort, TOT_B);
        #1;
        check("model_a", act_a(), model_out(pos_a, 4, 64, 16, 32, 32));
        check("model_b", act_b(), model_out(pos_b, 1, 1, 1, 1, 1));
        check_inv("dut_a", act_a());
        check_inv("dut_b", act_b());
    endtask

    initial begin
        tbl[0]  = '{1,   3'd1, 1'b1, 1'b0, 13'h1FF8, 4'hF, 5'h1E};
        tbl[1]  = '{64,  3'd1, 1'b1, 1'b0, 13'h1FF8, 4'hF, 5'h1E};
        tbl[2]  = '{65,  3'd2, 1'b1, 1'b0, 13'h1F87, 4'hF, 5'h1E};
        tbl[3]  = '{69,  3'd2, 1'b1, 1'b0, 13'h1F87, 4'hF, 5'h1D};
        tbl[4]  = '{73,  3'd2, 1'b1, 1'b0, 13'h1F87, 4'hF, 5'h1B};
        tbl[5]  = '{77,  3'd2, 1'b1, 1'b0, 13'h1F87, 4'hF, 5'h1E};
        tbl[6]  = '{256, 3'd2, 1'b1, 1'b0, 13'h1F87, 4'hF, 5'h1B};
        tbl[7]  = '{257, 3'd3, 1'b1, 1'b0, 13'h1E7F, 4'hF, 5'h17};
        tbl[8]  = '{261, 3'd3, 1'b1, 1'b0, 13'h1E7F, 4'hF, 5'h0F};
        tbl[9]  = '{265, 3'd3, 1'b1, 1'b0, 13'h1E7F, 4'hF, 5'h17};
        tbl[10] = '{269, 3'd3, 1'b1, 1'b0, 13'h1E7F, 4'hF, 5'h17};
        tbl[11] = '{273, 3'd3, 1'b1, 1'b0, 13'h1E7F, 4'hF, 5'h0F};
        tbl[12] = '{289, 3'd4, 1'b1, 1'b0, 13'h01FF, 4'h0, 5'h1F};
        tbl[13] = '{320, 3'd4, 1'b1, 1'b0, 13'h01FF, 4'h0, 5'h1F};
        tbl[14] = '{321, 3'd5, 1'b0, 1'b1, 13'h1FFF, 4'hF, 5'h1F};
        tbl[15] = '{322, 3'd0, 1'b0, 1'b0, 13'h1FFF, 4'hF, 5'h1F};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pos_a = -1; pos_b = -1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", act_a(), SAFE);
        check("reset_b", act_b(), SAFE);
        rst = 1'b0;
        step();

        // Full default protocol against hand-computed checkpoints.
        start = 1'b1; step(); start = 1'b0; cyc = 1;
        for (int i = 0; i < 16; i++) begin
            while (cyc < tbl[i].cyc) begin step(); cyc++; end
            check($sformatf("table[%0d]", i), act_a(),
                  {tbl[i].st, tbl[i].bz, tbl[i].dn, tbl[i].c, tbl[i].s, tbl[i].p});
        end

        // Asynchronous reset in MIX.
        start = 1'b1; step(); start = 1'b0;
        repeat (99) step();
        check("in_mix", {29'd0, a_state} , 32'd2);
        rst = 1'b1; #1;
        pos_a = -1; pos_b = -1;
        check("rst_immediate_a", act_a(), SAFE);
        check("rst_immediate_b", act_b(), SAFE);
        step(); step();
        rst = 1'b0;
        repeat (3) step();
        check("idle_after_rst", act_a(), SAFE);

        // Abort 10 cycles into WASH, with a simultaneous start that must be ignored.
        start = 1'b1; step(); start = 1'b0; cyc = 1;
        while (cyc < 267) begin step(); cyc++; end
        check("wash_plus10", {29'd0, a_state}, 32'd3);
        abort = 1'b1; start = 1'b1; step();
        abort = 1'b0; start = 1'b0;
        check("abort_safe", act_a(), SAFE);
        step();
        check("abort_start_ignored", act_a(), SAFE);

        // start held high: one protocol per 322-cycle period.
        start = 1'b1; step(); cyc = 1;
        while (cyc < 321) begin step(); cyc++; end
        check("held_done", act_a(), {3'd5, 1'b0, 1'b1, 13'h1FFF, 4'hF, 5'h1F});
        step(); cyc++;
        check("held_idle", act_a(), SAFE);
        step(); cyc++;
        check("held_restart", act_a(), {3'd1, 1'b1, 1'b0, 13'h1FF8, 4'hF, 5'h1E});
        abort = 1'b1; start = 1'b0; step(); abort = 1'b0;

        // Randomized traffic against the protocol-position model.
        for (int i = 0; i < 6000; i++) begin
            start = ($urandom % 8) == 0;
            abort = ($urandom % 700) == 0;
            rst   = ($urandom % 3000) == 0;
            step();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kinase_activity_ctrl.md
# kinase_activity_ctrl

Protocol sequencer that drives the pneumatic control lines of one kinase-activity assay chip. It generates every valve/pump line: 13 channel valves, 4 sieve valves, 5 pump valves. The outputs fan out unchanged to both assay lanes of the dual-lane device, which share all control lines. It runs a fixed LOAD → MIX → WASH → ELUTE protocol on a single start command, with peristaltic pump phasing and abort.

## Interface
Parameters:
- PHASE_CYCLES, 4, clock cycles each pump phase is held (≥1)
- LOAD_CYCLES, 64, duration of LOAD (≥1)
- MIX_ROUNDS, 16, full 3-phase pump rotations in MIX (≥1)
- WASH_CYCLES, 32, duration of WASH (≥1)
- ELUTE_CYCLES, 32, duration of ELUTE (≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  input  1  sole clock, rising edge
  - rst  input  1  asynchronous, active-high reset
- Command inputs:
  - start  input  1  begin protocol; sampled only in IDLE
  - abort  input  1  return to IDLE immediately; priority over start
- Status outputs:
  - busy  output  1  high in LOAD/MIX/WASH/ELUTE
  - done  output  1  one-cycle pulse in DONE
  - state  output  3  IDLE=0, LOAD=1, MIX=2, WASH=3, ELUTE=4, DONE=5
- Control-line outputs:
  - c  output  13  channel valves; bit i drives c(i+1)
  - s  output  4  sieve valves; bit i drives s(i+1)
  - p  output  5  pump valves; bit i drives p(i+1)

## Operation
- Polarity: 1 = valve pressurised (closed), 0 = open.
- "Safe" pattern: c=13'h1FFF, s=4'hF, p=5'h1F, i.e. everything closed.
- All outputs are registered and change on the same edge as `state`.
- Pump rotation:
  - ph counter 0..2 restarts at 0 on every state entry.
  - ph advances after each PHASE_CYCLES cycles and wraps 2→0.
  - ROT3 pattern on p[2:0]: ph0=3'b110, ph1=3'b101, ph2=3'b011.
  - ALT2 pattern on p[4:3]: ph even=2'b10, ph odd=2'b01, using ph mod 2. The 0/1/2 sequence gives 10,01,10,10,01,10,…
- States (bits not listed = 1):
  - IDLE: safe pattern. If start && !abort, go to LOAD.
  - LOAD: c[2:0]=0 (inlets), p[2:0]=ROT3. Lasts LOAD_CYCLES, then MIX.
  - MIX: c[6:3]=0 (mixer ring), p[2:0]=ROT3. Lasts MIX_ROUNDS×3×PHASE_CYCLES, then WASH.
  - WASH: c[8:7]=0 (wash inlet/waste), s=4'hF (beads retained), p[4:3]=ALT2. Lasts WASH_CYCLES, then ELUTE.
  - ELUTE: c[12:9]=0, s=4'h0 (sieves open), p=5'h1F. Lasts ELUTE_CYCLES, then DONE.
  - DONE: safe pattern, done=1 for one cycle, then IDLE.
- Dwell counter: width sufficient for max(LOAD_CYCLES, MIX_ROUNDS×3×PHASE_CYCLES, WASH_CYCLES, ELUTE_CYCLES). Reloads on every state entry; no wrap is possible.
- abort: in any state, the next edge gives state=IDLE, safe pattern, busy=0, done=0. Abort in DONE suppresses nothing, since done is already being output that cycle.
- start while busy or in DONE is ignored; no queueing.
- Invariant: at no time are c[2:0] and c[12:9] both open, so the inlet and elution paths are never simultaneously open.

## Timing
- Reset (async assert): state=IDLE, safe pattern, busy=0, done=0, counters=0. Deassertion takes effect at the next edge.
- Reset mid-protocol behaves identically to abort, except that it is immediate (asynchronous).
- start sampled high at edge k (in IDLE):
  - LOAD occupies cycles k+1 … k+L.
  - MIX occupies the next M = MIX_ROUNDS×3×PHASE_CYCLES cycles.
  - WASH occupies the next W cycles, then ELUTE the next E cycles.
  - DONE is at cycle k+1+L+M+W+E.
  - IDLE resumes one cycle later; earliest restart start is sampled there.
- First pump phase change occurs PHASE_CYCLES cycles after state entry.

## Test plan
- Reset during MIX → all outputs immediately safe pattern, state=0, busy=0; after release, idle until start.
- Defaults, start pulse at k:
  - state=1 at k+1 with c=13'h1FF8, p=5'h1E.
  - state=2 at k+65; state=3 at k+257; state=4 at k+289.
  - done=1 only at k+321; state=0 at k+322.
- MIX pump check (defaults): p[2:0] is 110 for cycles 0-3, 101 for 4-7, 011 for 8-11, then 110 again. 16 rotations give exactly 192 cycles.
- abort asserted 10 cycles into WASH → next cycle state=0, safe pattern; start in the same cycle as abort is ignored.
- start held high continuously → one protocol per 322-cycle period (321 cycles + 1 IDLE); no start is accepted while busy.
- Monitor over all runs (PHASE_CYCLES=1, all durations=1 corner included): the inlet/elution exclusivity invariant holds, and done is never high while busy=1.
